counter_updown_mod: RTL and testbench
=====================================

Name: counter_updown_mod

Overview:
- Parametrised synchronous up/down counter; successor to the fixed 4-bit up-counter.
- Adds:
  - configurable width and modulus
  - direction control and parallel load
  - synchronous clear
  - wrap or saturate mode
  - registered terminal-count pulse and sticky overflow flag
- Next-state increment/decrement is a ripple chain of per-bit add/sub cells, as in the earlier half-adder counter.
- Used as a general event/timer counter by datapath and control blocks.

Parameters:
- WIDTH, 8, counter width in bits; legal range 1..32.
- MAX_VAL, 2**WIDTH-1, highest count value (modulus-1); legal range 1..2**WIDTH-1.
- SATURATE, 0, 0 = wrap at boundaries, 1 = hold at boundaries.

Ports:
- clk  input  1  rising-edge clock
- res  input  1  reset, asynchronous, active-high
- clr  input  1  synchronous clear
- load  input  1  synchronous parallel load strobe
- load_val  input  WIDTH  value loaded when load=1
- en  input  1  count enable
- up  input  1  direction: 1 = increment, 0 = decrement
- cnt  output  WIDTH  current count (registered)
- tc  output  1  terminal-count pulse (registered)
- ovf  output  1  sticky overflow/underflow flag (registered)

Behaviour:
- Clock and reset:
  - One clock, clk.
  - Reset res is asynchronous and active-high.
  - While res=1: cnt=0, tc=0, ovf=0, independent of clk.
  - Counting resumes on the first rising clk edge after res deasserts.
- Per-edge priority: clr > load > en. Exactly one action per edge.
- clr=1: cnt<=0, tc<=0, ovf<=0.
- load=1 (clr=0):
  - cnt<=load_val, clamped to MAX_VAL when load_val > MAX_VAL.
  - tc<=0; ovf unchanged.
- en=1, up=1, no clr/load:
  - cnt < MAX_VAL: cnt<=cnt+1, tc<=0.
  - cnt == MAX_VAL: cnt<=0 (SATURATE=0) or MAX_VAL (SATURATE=1); tc<=1, ovf<=1.
- en=1, up=0, no clr/load:
  - cnt > 0: cnt<=cnt-1, tc<=0.
  - cnt == 0: cnt<=MAX_VAL (SATURATE=0) or 0 (SATURATE=1); tc<=1, ovf<=1.
- en=0, no clr/load: cnt holds, tc<=0, ovf holds.
- tc timing:
  - tc is high in the cycle after the boundary edge, i.e. the same cycle the wrapped/saturated cnt is visible.
  - It is a single-cycle pulse per boundary event.
  - In saturate mode it re-pulses on every enabled edge while held at the boundary.
- ovf: set by any boundary event; cleared only by clr or res.
- up may change on any cycle; it takes effect on the next edge with no extra latency.
- Arithmetic, ripple chain of WIDTH add/sub cells:
  - Cell 0 carry-in = 1.
  - sum[i] = q[i] XOR c[i].
  - Carry-out = q[i] & c[i] when up=1; ~q[i] & c[i] when up=0.
  - Boundary detection is by comparison of cnt with MAX_VAL/0, not by final carry, so non-power-of-two moduli work.
  - The cnt register never holds a value > MAX_VAL.
- Elaboration-time assertions reject out-of-range WIDTH or MAX_VAL.
- All outputs are registered; no combinational path from inputs to outputs.

Decomposition:
- Package counter_pkg:
  - direction constants DIR_UP=1'b1, DIR_DOWN=1'b0
  - mode constants MODE_WRAP=0, MODE_SAT=1
  - function clamp_to_max(value, max) used by load path and bench
- Sub-module addsub_cell: 1-bit half adder/subtractor.
  - Inputs a, cin, up; outputs sum, cout.
  - Instantiated WIDTH times via generate loop.

Test Plan:
- Async reset mid-count: WIDTH=4, MAX_VAL=9; count 0->5, raise res between edges -> cnt=0, tc=0, ovf=0 before next edge; release res -> cnt=1 after first enabled edge.
- Up wrap: WIDTH=4, MAX_VAL=9, SATURATE=0, en=1, up=1 for 11 edges from 0 -> cnt 1..9,0,1; tc=1 only while cnt=0 after wrap; ovf=1 from then on.
- Down wrap: same config, cnt=0, en=1, up=0 -> cnt=9, tc pulse one cycle, ovf=1; next edge cnt=8, tc=0.
- Saturate: WIDTH=4, MAX_VAL=15, SATURATE=1; load 14, then up 3 edges -> cnt 15,15,15; tc=0,1,1; down 2 edges from 15 -> 14,13, tc=0.
- Priority/clamp: MAX_VAL=9; clr=load=en=1 -> cnt=0, ovf=0; load=1, load_val=12 -> cnt=9; load=1, en=1, load_val=3 -> cnt=3, not 4.
- Hold: en=0 with up toggling for 5 edges at cnt=6 -> cnt stays 6, tc=0, ovf unchanged.

Source files
------------

// File: rtl/counter_updown_mod_pkg.sv
// Shared constants and helpers for the parametrised up/down counter.
// Also imported by the bench so both sides clamp loads the same way.
package counter_pkg;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  localparam int MODE_WRAP = 0;
  localparam int MODE_SAT  = 1;

  function automatic logic [31:0] clamp_to_max(input logic [31:0] value,
                                               input logic [31:0] max_val);
    return (value > max_val) ? max_val : value;
  endfunction

endpackage

// File: rtl/counter_updown_mod_addsub_cell.sv
// One bit of the increment/decrement ripple chain.
// It is a half adder when counting up and a half subtractor when counting down.
module addsub_cell
  import counter_pkg::*;
(
  input  logic a,
  input  logic cin,
  input  logic up,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ cin;
  // Down: a borrow propagates through bits that are already zero.
  assign cout = (up == DIR_UP) ? (a & cin) : (~a & cin);

endmodule

// File: rtl/counter_updown_mod.sv
// Up/down event counter with configurable width and modulus.
// Supports wrap or saturate at the boundaries, parallel load, a terminal-count pulse and a sticky overflow flag.
module counter_updown_mod
  import counter_pkg::*;
#(
  parameter int              WIDTH    = 8,
  parameter longint unsigned MAX_VAL  = (64'd1 << WIDTH) - 64'd1,
  parameter int              SATURATE = MODE_WRAP
) (
  input  logic             clk,
  input  logic             res,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic             up,
  output logic [WIDTH-1:0] cnt,
  output logic             tc,
  output logic             ovf
);

  if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
    $fatal(1, "counter_updown_mod: WIDTH out of range 1..32");
  end
  if (MAX_VAL < 64'd1 || MAX_VAL > ((64'd1 << WIDTH) - 64'd1)) begin : g_bad_max
    $fatal(1, "counter_updown_mod: MAX_VAL out of range 1..2**WIDTH-1");
  end
  if (SATURATE != MODE_WRAP && SATURATE != MODE_SAT) begin : g_bad_mode
    $fatal(1, "counter_updown_mod: SATURATE must be 0 or 1");
  end

  localparam logic [WIDTH-1:0] MAX = WIDTH'(MAX_VAL);

  logic [WIDTH-1:0] cnt_reg, cnt_next;
  logic [WIDTH-1:0] step;
  logic [WIDTH-1:0] load_clamped;
  logic [WIDTH:0]   carry;
  logic             tc_reg, tc_next;
  logic             ovf_reg, ovf_next;
  logic             at_max, at_zero;

  assign carry[0] = 1'b1;

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_chain
    addsub_cell u_cell (
      .a    (cnt_reg[gi]),
      .cin  (carry[gi]),
      .up   (up),
      .sum  (step[gi]),
      .cout (carry[gi+1])
    );
  end

  assign load_clamped = WIDTH'(clamp_to_max(32'(load_val), 32'(MAX)));
  assign at_max       = (cnt_reg == MAX);
  assign at_zero      = (cnt_reg == '0);

  always_comb begin
    cnt_next = cnt_reg;
    tc_next  = 1'b0;
    ovf_next = ovf_reg;
    if (clr) begin
      cnt_next = '0;
      ovf_next = 1'b0;
    end else if (load) begin
      cnt_next = load_clamped;
    end else if (en) begin
      if (up == DIR_UP && at_max) begin
        cnt_next = (SATURATE == MODE_SAT) ? MAX : '0;
        tc_next  = 1'b1;
        ovf_next = 1'b1;
      end else if (up == DIR_DOWN && at_zero) begin
        cnt_next = (SATURATE == MODE_SAT) ? '0 : MAX;
        tc_next  = 1'b1;
        ovf_next = 1'b1;
      end else begin
        cnt_next = step;
      end
    end
  end

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      cnt_reg <= '0;
      tc_reg  <= 1'b0;
      ovf_reg <= 1'b0;
    end else begin
      cnt_reg <= cnt_next;
      tc_reg  <= tc_next;
      ovf_reg <= ovf_next;
    end
  end

  // The chain's final carry is not used for boundary detection because non-power-of-two moduli need a compare.
  // The carry must still agree with the all-ones and all-zeros cases.
  always_ff @(posedge clk) begin
    if (!res) begin
      assert (carry[WIDTH] == ((up == DIR_UP) ? (cnt_reg == '1) : (cnt_reg == '0)));
    end
  end

  assign cnt = cnt_reg;
  assign tc  = tc_reg;
  assign ovf = ovf_reg;

endmodule

// File: tb/tb_counter_updown_mod.sv
// Bench for two counter configurations that share one stimulus stream.
// Instance a is MAX_VAL=9 with wrap; instance b is MAX_VAL=15 with saturate.
module tb_counter_updown_mod;
  import counter_pkg::*;

  logic       clk = 1'b0;
  logic       res = 1'b1;
  logic       clr = 1'b0;
  logic       load = 1'b0;
  logic [3:0] load_val = '0;
  logic       en = 1'b0;
  logic       up = 1'b1;
  logic [3:0] cnt_a, cnt_b;
  logic       tc_a, tc_b, ovf_a, ovf_b;

  counter_updown_mod #(.WIDTH(4), .MAX_VAL(9), .SATURATE(0)) dut_a (
    .clk(clk), .res(res), .clr(clr), .load(load), .load_val(load_val),
    .en(en), .up(up), .cnt(cnt_a), .tc(tc_a), .ovf(ovf_a)
  );

  counter_updown_mod #(.WIDTH(4), .MAX_VAL(15), .SATURATE(1)) dut_b (
    .clk(clk), .res(res), .clr(clr), .load(load), .load_val(load_val),
    .en(en), .up(up), .cnt(cnt_b), .tc(tc_b), .ovf(ovf_b)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;
  int phase = 0;

  // Reference state of each configuration.
  int m_cnt [2] = '{0, 0};
  bit m_tc  [2] = '{0, 0};
  bit m_ovf [2] = '{0, 0};
  int m_max [2] = '{9, 15};
  bit m_sat [2] = '{0, 1};

  typedef struct {
    int due;
    int ph;
    int cnt0, cnt1;
    bit tc0, tc1, ovf0, ovf1;
  } exp_t;
  exp_t sb[$];

  task automatic chk(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s (phase %0d, cycle %0d): got %0d, expected %0d", name, phase, cyc, act, req);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_cnt[i] = 0;
      m_tc[i]  = 0;
      m_ovf[i] = 0;
    end
  endtask

  task automatic model_apply(input bit c, input bit l, input int lv, input bit e, input bit u);
    bit bound;
    for (int i = 0; i < 2; i++) begin
      if (c) begin
        m_cnt[i] = 0; m_tc[i] = 0; m_ovf[i] = 0;
      end else if (l) begin
        m_cnt[i] = int'(clamp_to_max(32'(lv), 32'(m_max[i])));
        m_tc[i]  = 0;
      end else if (e) begin
        bound = u ? (m_cnt[i] == m_max[i]) : (m_cnt[i] == 0);
        if (m_sat[i])
          m_cnt[i] = u ? ((m_cnt[i] + 1 > m_max[i]) ? m_max[i] : m_cnt[i] + 1)
                       : ((m_cnt[i] - 1 < 0) ? 0 : m_cnt[i] - 1);
        else
          m_cnt[i] = u ? (m_cnt[i] + 1) % (m_max[i] + 1)
                       : (m_cnt[i] + m_max[i]) % (m_max[i] + 1);
        m_tc[i] = bound;
        if (bound) m_ovf[i] = 1;
      end else begin
        m_tc[i] = 0;
      end
    end
  endtask

  // Inputs are applied at a falling edge, so the result is visible after the next rising edge.
  task automatic step(input bit c, input bit l, input int lv, input bit e, input bit u);
    exp_t x;
    @(negedge clk);
    clr = c; load = l; load_val = 4'(lv); en = e; up = u;
    model_apply(c, l, lv, e, u);
    x.due = cyc + 1; x.ph = phase;
    x.cnt0 = m_cnt[0]; x.tc0 = m_tc[0]; x.ovf0 = m_ovf[0];
    x.cnt1 = m_cnt[1]; x.tc1 = m_tc[1]; x.ovf1 = m_ovf[1];
    sb.push_back(x);
  endtask

  task automatic idle();
    step(0, 0, 0, 0, up);
  endtask

  task automatic check_now_zero(input string tag);
    chk({tag, ".cnt_a"}, int'(cnt_a), 0);
    chk({tag, ".tc_a"},  int'(tc_a),  0);
    chk({tag, ".ovf_a"}, int'(ovf_a), 0);
    chk({tag, ".cnt_b"}, int'(cnt_b), 0);
    chk({tag, ".tc_b"},  int'(tc_b),  0);
    chk({tag, ".ovf_b"}, int'(ovf_b), 0);
  endtask

  // Monitor: compares every expectation whose edge has passed.
  always @(negedge clk) begin
    exp_t e;
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      e = sb.pop_front();
      $display("txn ph=%0d cyc=%0d a: cnt=%0d tc=%0d ovf=%0d (exp %0d/%0d/%0d) b: cnt=%0d tc=%0d ovf=%0d (exp %0d/%0d/%0d)",
               e.ph, cyc, cnt_a, tc_a, ovf_a, e.cnt0, e.tc0, e.ovf0,
               cnt_b, tc_b, ovf_b, e.cnt1, e.tc1, e.ovf1);
      chk("cnt_a", int'(cnt_a), e.cnt0);
      chk("tc_a",  int'(tc_a),  int'(e.tc0));
      chk("ovf_a", int'(ovf_a), int'(e.ovf0));
      chk("cnt_b", int'(cnt_b), e.cnt1);
      chk("tc_b",  int'(tc_b),  int'(e.tc1));
      chk("ovf_b", int'(ovf_b), int'(e.ovf1));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state.
    phase = 0;
    repeat (3) @(negedge clk);
    check_now_zero("reset");
    #1 res = 1'b0;
    model_reset();

    // Count up through the wrap (a) and saturation (b), then on to 5.
    phase = 1;
    for (int i = 0; i < 11; i++) step(0, 0, 0, 1, DIR_UP);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 1, DIR_UP);
    idle();

    // Asynchronous reset asserted between edges, observed before the next edge.
    phase = 2;
    @(negedge clk);
    #1 res = 1'b1;
    #1 check_now_zero("async_reset");
    model_reset();
    #1 res = 1'b0;
    step(0, 0, 0, 1, DIR_UP);
    idle();

    // Down wrap from 0 (a), hold at 0 with repeated pulses (b).
    phase = 3;
    step(1, 0, 0, 0, DIR_UP);
    step(0, 0, 0, 1, DIR_DOWN);
    step(0, 0, 0, 1, DIR_DOWN);
    idle();

    // Saturate at the top, then count back down.
    phase = 4;
    step(0, 1, 14, 0, DIR_UP);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1, DIR_UP);
    for (int i = 0; i < 2; i++) step(0, 0, 0, 1, DIR_DOWN);
    idle();

    // Priority of clear over load over count, and clamping on load.
    phase = 5;
    step(1, 1, 7, 1, DIR_UP);
    step(0, 1, 12, 0, DIR_UP);
    step(0, 1, 3, 1, DIR_UP);
    idle();

    // Hold while up toggles; ovf is made sticky first.
    phase = 6;
    step(0, 1, 0, 0, DIR_UP);
    step(0, 0, 0, 1, DIR_DOWN);
    step(0, 1, 6, 0, DIR_UP);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0, (i % 2) == 0);

    // Randomised traffic.
    phase = 7;
    for (int i = 0; i < 300; i++) begin
      step($urandom_range(0, 31) == 0, $urandom_range(0, 7) == 0, int'($urandom_range(0, 15)),
           $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1);
    end
    idle();

    // Drain the scoreboard within a bounded number of cycles.
    for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: got %0d pending entries, expected 0", sb.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
